// File: rtl/uart_tx_scheduler.sv
// Purpose : arbitrates N_REQ byte streams onto one UART transmit FIFO (round-robin,
//           whole-packet grants) and sequences transmitter reconfiguration (drain, request, ack/timeout).
// Latency : zero-latency byte path (tx_data_o/tx_fifo_write_o combinational from the granted requester);
//           one idle cycle between packets while the next owner is chosen.
// Backpr. : tx_fifo_full_i deasserts req_ready_o of the owner; the grant is held until its last byte.
// Ports   : clk_i/rst_n_i (sync, active-low); req_valid_i/req_data_i/req_last_i/req_ready_o per requester;
//           grant_o one-hot owner; tx_data_o/tx_fifo_write_o/tx_fifo_full_i/tx_fifo_empty_i/tx_idle_i to the
//           transmitter; cfg_req_i/config_req_mst_o/req_done_i/cfg_ack_o/cfg_err_o config handshake; busy_o.
module uart_tx_scheduler #(
    parameter int N_REQ       = 4,
    parameter int CFG_TIMEOUT = 2000000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_fifo_write_o,
    input  logic               tx_fifo_full_i,
    input  logic               tx_fifo_empty_i,
    input  logic               tx_idle_i,
    input  logic               cfg_req_i,
    output logic               config_req_mst_o,
    input  logic               req_done_i,
    output logic               cfg_ack_o,
    output logic               cfg_err_o,
    output logic               busy_o
);

    localparam int          IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [31:0] TO_LAST = 32'(CFG_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, CONFIG} state_t;

    state_t           state;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    cur_idx;
    logic [N_REQ-1:0] grant_q;
    logic             cfg_mst_q;
    logic [31:0]      cfg_cnt;

    logic [IW-1:0]    rr_idx;
    logic [IW-1:0]    cand;
    logic             rr_found;
    logic [N_REQ-1:0] rr_onehot;
    logic [7:0]       sel_byte;
    logic             in_stream;
    logic             in_config;
    logic             beat;
    logic             last_beat;
    logic             timeout_hit;

    // Round-robin: scan starting one past the previous owner, first valid wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last_grant) + i) % N_REQ);
            if (!rr_found && req_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        rr_onehot         = '0;
        rr_onehot[rr_idx] = 1'b1;
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (cur_idx == IW'(k)) sel_byte = req_data_i[8*k +: 8];
        end
    end

    // Every output is gated by rst_n_i so the block is silent during the reset cycle
    // itself, not only after the reset edge.
    assign in_stream   = rst_n_i && (state == STREAM);
    assign in_config   = rst_n_i && (state == CONFIG);
    assign req_ready_o = {N_REQ{in_stream & ~tx_fifo_full_i}} & grant_q;
    assign beat        = |(req_ready_o & req_valid_i);
    assign last_beat   = beat & req_last_i[cur_idx];
    assign timeout_hit = (cfg_cnt == TO_LAST);

    assign tx_fifo_write_o  = beat;
    assign tx_data_o        = in_stream ? sel_byte : 8'h00;
    assign grant_o          = rst_n_i ? grant_q : '0;
    assign config_req_mst_o = rst_n_i & cfg_mst_q;
    // A completion arriving on the timeout cycle counts as success.
    assign cfg_ack_o        = in_config & req_done_i;
    assign cfg_err_o        = in_config & timeout_hit & ~req_done_i;
    assign busy_o           = rst_n_i && (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            cur_idx    <= '0;
            grant_q    <= '0;
            cfg_mst_q  <= 1'b0;
            cfg_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_req_i) begin
                        state <= DRAIN;
                    end else if (rr_found) begin
                        state   <= STREAM;
                        cur_idx <= rr_idx;
                        grant_q <= rr_onehot;
                    end
                end
                STREAM: begin
                    // Only the last beat releases the grant; a valid gap does not.
                    if (last_beat) begin
                        state      <= IDLE;
                        last_grant <= cur_idx;
                        grant_q    <= '0;
                    end
                end
                DRAIN: begin
                    if (tx_fifo_empty_i && tx_idle_i) begin
                        state     <= CONFIG;
                        cfg_cnt   <= '0;
                        cfg_mst_q <= 1'b1;
                    end
                end
                CONFIG: begin
                    if (req_done_i || timeout_hit) begin
                        state     <= IDLE;
                        cfg_mst_q <= 1'b0;
                    end else begin
                        cfg_cnt <= cfg_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
